spi_cmd_sched: RTL

//  Command scheduler in front of spi_master_byte. Shares one SPI byte master between
//  N_REQ register-access requesters (round-robin). Builds each frame: instruction

---
 rtl/spi_cmd_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_sched.sv
// Round-robin command scheduler that shares one SPI byte master between N_REQ requesters.
// Each frame is an instruction byte {rw, pad, addr} followed by nbytes data bytes.
module spi_cmd_sched #(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 7,
    parameter int MAX_BYTES   = 4,
    parameter int NB_W        = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             req_rw,
    input  logic [N_REQ*ADDR_W-1:0]      req_addr,
    input  logic [N_REQ*8*MAX_BYTES-1:0] req_wdata,
    input  logic [N_REQ*NB_W-1:0]        req_nbytes,
    output logic [N_REQ-1:0]             ack,
    output logic                         err,
    output logic [8*MAX_BYTES-1:0]       rdata,
    output logic                         busy,
    output logic                         have_data,
    output logic [7:0]                   data_o,
    input  logic                         rdreq,
    input  logic                         wrreq,
    input  logic [7:0]                   miso_reg,
    input  logic                         cs_n
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = NB_W + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_DONE} state_t;

    state_t                 state_q;
    logic [GW-1:0]          last_grant_q, grant_q;
    logic                   rw_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [8*MAX_BYTES-1:0] wdata_q;
    logic [NB_W-1:0]        nbytes_q;
    logic [NB_W-1:0]        idx_q;
    logic [CW-1:0]          rxcnt_q, rxcnt_d;
    logic [TW-1:0]          tmo_q;
    logic [N_REQ-1:0]       ack_q;
    logic                   err_q;
    logic [8*MAX_BYTES-1:0] rdata_q;
    logic                   have_data_q;
    logic [7:0]             data_q;

    logic                   found;
    logic [GW-1:0]          sel;
    logic                   sel_rw;
    logic [ADDR_W-1:0]      sel_addr;
    logic [8*MAX_BYTES-1:0] sel_wdata;
    logic [NB_W-1:0]        sel_nb;
    logic                   sel_bad;
    logic [7:0]             sel_instr;
    logic [7:0]             wbyte;
    logic                   rx_take, rx_store;

    // Two passes give round-robin order: indices above last grant first, then wrap to 0.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_nb    = '0;
        for (int c = 0; c < N_REQ; c++) begin
            if (!found && req[c] && (GW'(c) > last_grant_q)) begin
                found     = 1'b1;
                sel       = GW'(c);
                sel_rw    = req_rw[c];
                sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[c*8*MAX_BYTES +: 8*MAX_BYTES];
                sel_nb    = req_nbytes[c*NB_W +: NB_W];
            end
        end
        for (int c = 0; c < N_REQ; c++) begin
            if (!found && req[c] && (GW'(c) <= last_grant_q)) begin
                found     = 1'b1;
                sel       = GW'(c);
                sel_rw    = req_rw[c];
                sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[c*8*MAX_BYTES +: 8*MAX_BYTES];
                sel_nb    = req_nbytes[c*NB_W +: NB_W];
            end
        end
        sel_bad   = (sel_nb == '0) || (sel_nb > NB_W'(MAX_BYTES));
        sel_instr = '0;
        sel_instr[7] = sel_rw;
        sel_instr[ADDR_W-1:0] = sel_addr;
    end

    always_comb begin
        wbyte    = 8'(wdata_q >> {idx_q, 3'b000});
        rx_take  = wrreq && ((state_q == S_SEND) || (state_q == S_DRAIN))
                   && (rxcnt_q <= CW'(nbytes_q));
        rx_store = rx_take && rw_q && (rxcnt_q != '0);
        rxcnt_d  = rxcnt_q + CW'(rx_take);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(N_REQ - 1);
            grant_q      <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            nbytes_q     <= '0;
            idx_q        <= '0;
            rxcnt_q      <= '0;
            tmo_q        <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            have_data_q  <= 1'b0;
            data_q       <= '0;
        end else begin
            rxcnt_q <= rxcnt_d;
            // Slot 0 is the instruction byte's echo, so received byte k lands in rdata byte k-1.
            for (int k = 0; k < MAX_BYTES; k++) begin
                if (rx_store && (rxcnt_q == CW'(k + 1))) rdata_q[k*8 +: 8] <= miso_reg;
            end
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        grant_q  <= sel;
                        rw_q     <= sel_rw;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        nbytes_q <= sel_nb;
                        idx_q    <= '0;
                        rxcnt_q  <= '0;
                        tmo_q    <= '0;
                        if (sel_bad) begin
                            state_q <= S_DONE;
                            ack_q   <= N_REQ'(1) << sel;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_SEND;
                            have_data_q <= 1'b1;
                            data_q      <= sel_instr;
                        end
                    end
                end
                S_SEND: begin
                    if (rdreq && have_data_q) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == nbytes_q) begin
                            have_data_q <= 1'b0;
                            data_q      <= '0;
                            state_q     <= S_DRAIN;
                        end else begin
                            data_q <= rw_q ? 8'h00 : wbyte;
                        end
                    end
                end
                S_DRAIN: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (cs_n) begin
                        state_q <= S_DONE;
                        ack_q   <= N_REQ'(1) << grant_q;
                        err_q   <= rw_q && (rxcnt_d <= CW'(nbytes_q));
                    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        state_q <= S_DONE;
                        ack_q   <= N_REQ'(1) << grant_q;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    ack_q        <= '0;
                    err_q        <= 1'b0;
                    last_grant_q <= grant_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign have_data = have_data_q;
    assign data_o    = data_q;

endmodule
